packet_sender_rr: RTL and testbench
===================================

# packet_sender_rr

Multi-channel successor to the single-buffer packet sender. It drains complete packets from NCH input packet buffers onto one shared output link. Channels are picked by round-robin arbitration, the link supports ready/valid backpressure, and packets go out back-to-back with no idle cycle between them. It sits between the per-port input buffers and the router crossbar/output port.

## Interface
- `UWIDTH`, 8, word width of buffers and output link
- `PTR_IN_SZ`, 4, buffer word-address width; must satisfy 2^PTR_IN_SZ >= 2^SIZE_BITS + 3
- `NCH`, 2, number of input channels (1..8)
- `SIZE_BITS`, 3, width of the payload-length field (low bits of SIZE word)

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `rempty`  in  NCH  per-channel "no complete packet stored"
- `rdata`  in  NCH*UWIDTH  per-channel async-read word at `raddr_in`; channel c at bits [c*UWIDTH +: UWIDTH]
- `raddr_in`  out  PTR_IN_SZ  shared read address, broadcast to all buffers
- `rinc`  out  NCH  one-hot one-cycle pulse: pop head packet of channel c
- `packet_out`  out  UWIDTH  `rdata` of granted channel (combinational mux)
- `packet_valid`  out  1  `packet_out` holds a packet word
- `packet_ready`  in  1  downstream accepts word
- `packet_sop`, `packet_eop`  out  1  first (SRC) / last (CRC) word qualifiers, valid with `packet_valid`
- `ch_id`  out  3  granted channel index
- `crc_err`  out  1  checksum mismatch flag (see Configuration)

## Operation
- Packet layout at buffer addresses 0..: SRC, DST, SIZE, DATA×N, CRC, where N = SIZE[SIZE_BITS-1:0]. N = 0 is legal. Total length is N+4 words.
- Transfer: a word moves when `packet_valid && packet_ready`.
- FSM states: IDLE, SRC, DST, SIZE, DATA, CRC. Each non-IDLE state advances only on a transfer.
  - IDLE: if any `rempty[c]`==0, grant a channel by round-robin, starting the search at last grant+1 (mod NCH). Set `raddr_in`=0 and go to SRC.
  - SRC→DST→SIZE.
  - SIZE: capture N into the down-counter `dsz`. Go to DATA if N≠0, else to CRC.
  - DATA: decrement `dsz` on each transfer. Go to CRC on the transfer with `dsz`==1.
  - CRC: on transfer, pulse `rinc[grant]` in the next cycle. Then re-arbitrate over the non-empty channels, excluding the finishing channel (its `rempty` is stale).
    - If a winner exists: go to SRC with `raddr_in`=0 and the new grant, with no gap.
    - Otherwise: go to IDLE.
- `raddr_in` increments by 1 on every transfer in SRC..DATA and wraps at 2^PTR_IN_SZ.
- When `packet_ready`=0: state, `raddr_in`, grant, and `packet_out` all hold stable.
- `packet_valid`=1 in every state except IDLE. `packet_sop`=1 in SRC. `packet_eop`=1 in CRC.

## Timing
- Reset values: state IDLE, `raddr_in`=0, `rinc`=0, `packet_valid`=0, `packet_sop`=0, `packet_eop`=0, `ch_id`=0, `crc_err`=0, round-robin pointer NCH-1 (so channel 0 wins first), `dsz`=0.
- Latency: `rempty[c]` falls in cycle t → SRC word valid in cycle t+1.
- Throughput: one word per cycle with `packet_ready` held high. A packet of N data words occupies exactly N+4 cycles.
- `rinc` is registered and is never asserted together with the address wrap for the next packet's SRC word from the same channel.
- Reset asserted mid-packet: immediate return to IDLE, no `rinc` issued, and the packet stays in its buffer.
- Simultaneous requests: only one grant per arbitration. The pointer updates to the granted channel.

## Configuration
- `PKT_CRC_CHECK_EN` defined:
  - Running XOR over SRC, DST, SIZE, and DATA words, computed on transfers.
  - On the CRC transfer, `crc_err` is registered high for one cycle if the XOR ≠ the CRC word.
  - The packet is still forwarded and popped.
- `PKT_CRC_CHECK_EN` undefined: no checksum logic; `crc_err` is tied to 0.

## Test plan
- Ch0 holds {0x01,0x02,0x02,0xA0,0xA1,CRC}, ready=1 → 6 valid cycles, sop on 0x01, eop on CRC, `rinc`=2'b01 one cycle after eop, then IDLE.
- Ch0 and ch1 both non-empty (N=1 each) → ch0 packet (5 cycles) immediately followed by ch1 SRC in the next cycle; `ch_id` goes 0→1; no valid gap.
- `packet_ready` held low for 3 cycles during DATA → `packet_out`, `raddr_in`, and state frozen; no extra words and no word lost.
- SIZE=0x00 packet → SRC, DST, SIZE, CRC only (4 cycles); `raddr_in` sequence 0,1,2,3.
- `rst` low during DST → outputs return to reset values; after release, the same packet is resent from SRC, with `rinc` never pulsed for the aborted attempt.
- With `PKT_CRC_CHECK_EN`: CRC word corrupted (0x00 instead of 0xA2) → `crc_err` pulses one cycle after eop, and the correct packet that follows gives `crc_err`=0.

Source files
------------

// File: rtl/packet_sender_rr_if.sv
// Handshake bundle between the packet buffers, packet_sender_rr and the output link.
// The master modport is the sender's view; the slave modport is the buffers/link view.
interface packet_sender_rr_if #(
  parameter int UWIDTH    = 8,
  parameter int PTR_IN_SZ = 4,
  parameter int NCH       = 2
);
  logic [NCH-1:0]        rempty;
  logic [NCH*UWIDTH-1:0] rdata;
  logic [PTR_IN_SZ-1:0]  raddr_in;
  logic [NCH-1:0]        rinc;
  logic [UWIDTH-1:0]     packet_out;
  logic                  packet_valid;
  logic                  packet_ready;
  logic                  packet_sop;
  logic                  packet_eop;
  logic [2:0]            ch_id;
  logic                  crc_err;

  modport master (
    input  rempty, rdata, packet_ready,
    output raddr_in, rinc, packet_out, packet_valid, packet_sop, packet_eop, ch_id, crc_err
  );

  modport slave (
    output rempty, rdata, packet_ready,
    input  raddr_in, rinc, packet_out, packet_valid, packet_sop, packet_eop, ch_id, crc_err
  );
endinterface

// File: rtl/packet_sender_rr.sv
// Round-robin multi-channel packet sender: drains whole packets from NCH buffers onto one link.
// Optional feature macro PKT_CRC_CHECK_EN enables the running-XOR checksum check on crc_err.
module packet_sender_rr #(
  parameter int UWIDTH    = 8,
  parameter int PTR_IN_SZ = 4,
  parameter int NCH       = 2,
  parameter int SIZE_BITS = 3
) (
  input logic               clk,
  input logic               rst,
  packet_sender_rr_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_SRC, S_DST, S_SIZE, S_DATA, S_CRC} state_t;

  state_t                 state_q, state_d;
  logic [2:0]             grant_q, grant_d;
  logic [2:0]             rr_ptr_q, rr_ptr_d;
  logic [PTR_IN_SZ-1:0]   raddr_q, raddr_d;
  logic [SIZE_BITS-1:0]   dsz_q, dsz_d;
  logic [NCH-1:0]         rinc_q, rinc_d;
  logic [UWIDTH-1:0]      word;
  logic [NCH-1:0]         gmask;
  logic [NCH-1:0]         req;
  logic                   xfer;
  logic                   arb_found;
  logic [2:0]             arb_win;

  function automatic logic [3:0] rr_pick(input logic [NCH-1:0] r, input logic [2:0] ptr);
    logic [3:0] res;
    int         idx;
    res = '0;
    for (int i = 1; i <= NCH; i++) begin
      idx = (int'(ptr) + i) % NCH;
      if (!res[3] && r[idx]) res = {1'b1, 3'(idx)};
    end
    return res;
  endfunction

  assign word = bus.rdata[int'(grant_q)*UWIDTH +: UWIDTH];
  assign xfer = (state_q != S_IDLE) && bus.packet_ready;

  // A channel whose pop is in flight (or is just finishing) still shows a stale rempty.
  always_comb begin
    for (int c = 0; c < NCH; c++) gmask[c] = (grant_q == 3'(c));
    req = ~bus.rempty & ~rinc_q;
    if (state_q == S_CRC) req = req & ~gmask;
    {arb_found, arb_win} = rr_pick(req, rr_ptr_q);
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    raddr_d  = raddr_q;
    dsz_d    = dsz_q;
    rinc_d   = '0;
    case (state_q)
      S_IDLE: if (arb_found) begin
        grant_d  = arb_win;
        rr_ptr_d = arb_win;
        raddr_d  = '0;
        state_d  = S_SRC;
      end
      S_SRC: if (xfer) begin
        raddr_d = raddr_q + PTR_IN_SZ'(1);
        state_d = S_DST;
      end
      S_DST: if (xfer) begin
        raddr_d = raddr_q + PTR_IN_SZ'(1);
        state_d = S_SIZE;
      end
      S_SIZE: if (xfer) begin
        raddr_d = raddr_q + PTR_IN_SZ'(1);
        dsz_d   = word[SIZE_BITS-1:0];
        state_d = (word[SIZE_BITS-1:0] != '0) ? S_DATA : S_CRC;
      end
      S_DATA: if (xfer) begin
        raddr_d = raddr_q + PTR_IN_SZ'(1);
        dsz_d   = dsz_q - SIZE_BITS'(1);
        if (dsz_q == SIZE_BITS'(1)) state_d = S_CRC;
      end
      S_CRC: if (xfer) begin
        rinc_d  = gmask;
        raddr_d = '0;
        if (arb_found) begin
          grant_d  = arb_win;
          rr_ptr_d = arb_win;
          state_d  = S_SRC;
        end else begin
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= 3'(NCH-1);
      raddr_q  <= '0;
      dsz_q    <= '0;
      rinc_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      raddr_q  <= raddr_d;
      dsz_q    <= dsz_d;
      rinc_q   <= rinc_d;
    end
  end

`ifdef PKT_CRC_CHECK_EN
  logic [UWIDTH-1:0] xor_q, xor_d;
  logic              crc_err_q, crc_err_d;

  // SRC restarts the running XOR, so the accumulator needs no reset.
  always_comb begin
    xor_d     = xor_q;
    crc_err_d = 1'b0;
    if (xfer) begin
      case (state_q)
        S_SRC:                xor_d     = word;
        S_DST, S_SIZE, S_DATA: xor_d    = xor_q ^ word;
        S_CRC:                crc_err_d = (xor_q != word);
        default:              xor_d     = xor_q;
      endcase
    end
  end

  always_ff @(posedge clk) xor_q <= xor_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) crc_err_q <= 1'b0;
    else      crc_err_q <= crc_err_d;
  end

  assign bus.crc_err = crc_err_q;
`else
  assign bus.crc_err = 1'b0;
`endif

  assign bus.raddr_in     = raddr_q;
  assign bus.rinc         = rinc_q;
  assign bus.packet_out   = word;
  assign bus.packet_valid = (state_q != S_IDLE);
  assign bus.packet_sop   = (state_q == S_SRC);
  assign bus.packet_eop   = (state_q == S_CRC);
  assign bus.ch_id        = grant_q;

endmodule

// File: tb/tb_packet_sender_rr.sv
// Directed bench for packet_sender_rr: two single-slot buffer models feed the sender.
module tb_packet_sender_rr;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  packet_sender_rr_if #(.UWIDTH(8), .PTR_IN_SZ(4), .NCH(2)) bus();

  packet_sender_rr #(.UWIDTH(8), .PTR_IN_SZ(4), .NCH(2), .SIZE_BITS(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] mem [2][16];
  int loaded [2];
  int popped [2];
  int errors = 0;
  int checks = 0;
  logic [17:0] got, exp;

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      bus.rempty[c]       = (loaded[c] == popped[c]);
      bus.rdata[c*8 +: 8] = mem[c][bus.raddr_in];
    end
  end

  always @(posedge clk) begin
    for (int c = 0; c < 2; c++) if (bus.rinc[c]) popped[c] <= popped[c] + 1;
  end

  always_comb got = {bus.packet_valid, bus.packet_sop, bus.packet_eop, bus.ch_id, bus.raddr_in, bus.packet_out};

  task automatic load(input int ch, input logic [7:0] p [8], input int n);
    for (int i = 0; i < n; i++) mem[ch][i] = p[i];
    loaded[ch]++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.packet_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.packet_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.packet_valid); end
    checks++; if ({bus.packet_sop, bus.packet_eop} !== 2'b00) begin errors++; $display("FAIL reset_sop_eop: got %b want 00", {bus.packet_sop, bus.packet_eop}); end
    checks++; if (bus.raddr_in !== 4'd0) begin errors++; $display("FAIL reset_raddr: got %0d want 0", bus.raddr_in); end
    checks++; if (bus.rinc !== 2'b00) begin errors++; $display("FAIL reset_rinc: got %b want 00", bus.rinc); end
    checks++; if (bus.ch_id !== 3'd0) begin errors++; $display("FAIL reset_ch_id: got %0d want 0", bus.ch_id); end
    checks++; if (bus.crc_err !== 1'b0) begin errors++; $display("FAIL reset_crc_err: got %b want 0", bus.crc_err); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.packet_valid !== 1'b0) begin errors++; $display("FAIL idle_empty_valid: got %b want 0", bus.packet_valid); end
  endtask

  // From reset the pointer is NCH-1, so channel 0 goes first, then channel 1 with no gap.
  task automatic test_back_to_back();
    logic [7:0] a [8], b [8];
    int ch, idx;
    a = '{8'h10, 8'h20, 8'h01, 8'h33, 8'h02, 8'h00, 8'h00, 8'h00};
    b = '{8'h40, 8'h50, 8'h01, 8'h66, 8'h77, 8'h00, 8'h00, 8'h00};
    load(0, a, 5);
    load(1, b, 5);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      ch  = (k < 5) ? 0 : 1;
      idx = k % 5;
      exp = {1'b1, idx == 0, idx == 4, 3'(ch), 4'(idx), (ch == 1) ? b[idx] : a[idx]};
      checks++; if (got !== exp) begin errors++; $display("FAIL b2b_word[%0d]: got %h want %h", k, got, exp); end
      if (k == 5) begin
        checks++; if (bus.rinc !== 2'b01) begin errors++; $display("FAIL b2b_rinc_ch0: got %b want 01", bus.rinc); end
      end
    end
    @(negedge clk);
    checks++; if ({bus.packet_valid, bus.rinc} !== 3'b010) begin errors++; $display("FAIL b2b_end: got %b want 010", {bus.packet_valid, bus.rinc}); end
    checks++; if (bus.crc_err !== 1'b0) begin errors++; $display("FAIL b2b_crc_err: got %b want 0", bus.crc_err); end
    @(negedge clk);
    checks++; if (bus.rinc !== 2'b00) begin errors++; $display("FAIL b2b_rinc_off: got %b want 00", bus.rinc); end
  endtask

  task automatic test_single();
    logic [7:0] p [8];
    p = '{8'h01, 8'h02, 8'h02, 8'hA0, 8'hA1, 8'h00, 8'h00, 8'h00};
    load(0, p, 6);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      exp = {1'b1, k == 0, k == 5, 3'd0, 4'(k), p[k]};
      checks++; if (got !== exp) begin errors++; $display("FAIL single_word[%0d]: got %h want %h", k, got, exp); end
    end
    @(negedge clk);
    checks++; if ({bus.packet_valid, bus.rinc} !== 3'b001) begin errors++; $display("FAIL single_rinc: got %b want 001", {bus.packet_valid, bus.rinc}); end
    @(negedge clk);
    checks++; if ({bus.packet_valid, bus.rinc} !== 3'b000) begin errors++; $display("FAIL single_idle: got %b want 000", {bus.packet_valid, bus.rinc}); end
  endtask

  task automatic test_backpressure();
    logic [7:0] p [8];
    int k, stall, cyc;
    p = '{8'h01, 8'h02, 8'h03, 8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'h00};
    load(0, p, 7);
    k = 0; stall = 0; cyc = 0;
    while (k < 7 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      exp = {1'b1, k == 0, k == 6, 3'd0, 4'(k), p[k]};
      checks++; if (got !== exp) begin errors++; $display("FAIL bp_word[%0d] cyc %0d: got %h want %h", k, cyc, got, exp); end
      if (k == 4 && stall < 3) begin
        bus.packet_ready = 1'b0;
        stall++;
      end else begin
        bus.packet_ready = 1'b1;
        k++;
      end
    end
    @(negedge clk);
    checks++; if ({bus.packet_valid, bus.rinc} !== 3'b001) begin errors++; $display("FAIL bp_rinc: got %b want 001", {bus.packet_valid, bus.rinc}); end
    @(negedge clk);
  endtask

  task automatic test_zero_size();
    logic [7:0] p [8];
    p = '{8'hAA, 8'hBB, 8'h00, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00};
    load(0, p, 4);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      exp = {1'b1, k == 0, k == 3, 3'd0, 4'(k), p[k]};
      checks++; if (got !== exp) begin errors++; $display("FAIL zero_word[%0d]: got %h want %h", k, got, exp); end
    end
    @(negedge clk);
    checks++; if ({bus.packet_valid, bus.rinc} !== 3'b001) begin errors++; $display("FAIL zero_rinc: got %b want 001", {bus.packet_valid, bus.rinc}); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [7:0] p [8];
    p = '{8'h5A, 8'hA5, 8'h01, 8'h77, 8'h89, 8'h00, 8'h00, 8'h00};
    load(0, p, 5);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      exp = {1'b1, k == 0, 1'b0, 3'd0, 4'(k), p[k]};
      checks++; if (got !== exp) begin errors++; $display("FAIL rmid_pre[%0d]: got %h want %h", k, got, exp); end
    end
    rst = 1'b0;
    #1;
    checks++; if ({bus.packet_valid, bus.packet_sop, bus.packet_eop, bus.ch_id, bus.raddr_in} !== 10'd0) begin
      errors++; $display("FAIL rmid_async: got %b want 0", {bus.packet_valid, bus.packet_sop, bus.packet_eop, bus.ch_id, bus.raddr_in});
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++; if (bus.rinc !== 2'b00) begin errors++; $display("FAIL rmid_rinc_held[%0d]: got %b want 00", k, bus.rinc); end
    end
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      exp = {1'b1, k == 0, k == 4, 3'd0, 4'(k), p[k]};
      checks++; if (got !== exp) begin errors++; $display("FAIL rmid_resend[%0d]: got %h want %h", k, got, exp); end
    end
    @(negedge clk);
    checks++; if (bus.rinc !== 2'b01) begin errors++; $display("FAIL rmid_rinc: got %b want 01", bus.rinc); end
    @(negedge clk);
    checks++; if (popped[0] !== loaded[0]) begin errors++; $display("FAIL rmid_pops: got %0d want %0d", popped[0], loaded[0]); end
  endtask

  task automatic test_crc();
    logic [7:0] p [8];
    logic want_err;
`ifdef PKT_CRC_CHECK_EN
    want_err = 1'b1;
`else
    want_err = 1'b0;
`endif
    p = '{8'h01, 8'h02, 8'h01, 8'hA0, 8'h00, 8'h00, 8'h00, 8'h00};
    load(0, p, 5);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      exp = {1'b1, k == 0, k == 4, 3'd0, 4'(k), p[k]};
      checks++; if (got !== exp) begin errors++; $display("FAIL crc_bad_word[%0d]: got %h want %h", k, got, exp); end
    end
    @(negedge clk);
    checks++; if ({bus.crc_err, bus.rinc} !== {want_err, 2'b01}) begin errors++; $display("FAIL crc_bad_flag: got %b want %b", {bus.crc_err, bus.rinc}, {want_err, 2'b01}); end
    @(negedge clk);
    checks++; if (bus.crc_err !== 1'b0) begin errors++; $display("FAIL crc_pulse_len: got %b want 0", bus.crc_err); end
    p[4] = 8'hA2;
    load(0, p, 5);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      exp = {1'b1, k == 0, k == 4, 3'd0, 4'(k), p[k]};
      checks++; if (got !== exp) begin errors++; $display("FAIL crc_good_word[%0d]: got %h want %h", k, got, exp); end
    end
    @(negedge clk);
    checks++; if ({bus.crc_err, bus.rinc} !== 3'b001) begin errors++; $display("FAIL crc_good_flag: got %b want 001", {bus.crc_err, bus.rinc}); end
    @(negedge clk);
  endtask

  // Last grant was channel 0, so the search starts at channel 1.
  task automatic test_round_robin();
    logic [7:0] a [8], b [8];
    int ch, idx;
    a = '{8'hC0, 8'hC1, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    b = '{8'hD0, 8'hD1, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    load(0, a, 4);
    load(1, b, 4);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      ch  = (k < 4) ? 1 : 0;
      idx = k % 4;
      exp = {1'b1, idx == 0, idx == 3, 3'(ch), 4'(idx), (ch == 1) ? b[idx] : a[idx]};
      checks++; if (got !== exp) begin errors++; $display("FAIL rr_word[%0d]: got %h want %h", k, got, exp); end
      if (k == 4) begin
        checks++; if (bus.rinc !== 2'b10) begin errors++; $display("FAIL rr_rinc_ch1: got %b want 10", bus.rinc); end
      end
    end
    @(negedge clk);
    checks++; if ({bus.packet_valid, bus.rinc} !== 3'b001) begin errors++; $display("FAIL rr_end: got %b want 001", {bus.packet_valid, bus.rinc}); end
    @(negedge clk);
  endtask

  initial begin
    for (int c = 0; c < 2; c++) for (int a = 0; a < 16; a++) mem[c][a] = 8'h00;
    test_reset();
    test_back_to_back();
    test_single();
    test_backpressure();
    test_zero_size();
    test_reset_mid();
    test_crc();
    test_round_robin();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
